// File: rtl/step_pulse_shaper_pkg.sv
// Shared types and defaults for the stepper STEP/DIR pulse shaper.
// Holds the FSM state encoding, default timing constants and width helpers.
package step_pulse_shaper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_e;

  localparam int DEF_HIGH_CYCLES      = 50;
  localparam int DEF_LOW_CYCLES       = 50;
  localparam int DEF_DIR_SETUP_CYCLES = 25;
  localparam int DEF_PEND_W           = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Wide enough to hold the largest load value itself, not just max-1.
  function automatic int timer_width(input int max_cycles);
    if (max_cycles < 2) return 1;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/step_pulse_shaper_timer.sv
// Loadable down-counter shared by the SETUP/HIGH/LOW phases of the shaper.
// A state loaded with N lasts exactly N cycles: done is raised on its last cycle.
module step_timer
  import step_pulse_shaper_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q <= W'(1));

endmodule

// File: rtl/step_pulse_shaper.sv
// Turns one-cycle step requests into STEP/DIR pulses that honour driver timing.
// A signed pending counter buffers bursts and cancels steps on reversal.
module step_pulse_shaper
  import step_pulse_shaper_pkg::*;
#(
  parameter int HIGH_CYCLES      = DEF_HIGH_CYCLES,
  parameter int LOW_CYCLES       = DEF_LOW_CYCLES,
  parameter int DIR_SETUP_CYCLES = DEF_DIR_SETUP_CYCLES,
  parameter int PEND_W           = DEF_PEND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_req,
  input  logic                     dir_req,
  input  logic                     enable,
  output logic                     step_out,
  output logic                     dir_out,
  output logic                     busy,
  output logic                     overflow,
  output logic signed [PEND_W-1:0] pending
);

  localparam int TIMER_W  = timer_width(max3(HIGH_CYCLES, LOW_CYCLES, DIR_SETUP_CYCLES));
  localparam int PEND_MAX = (2 ** (PEND_W - 1)) - 1;

  localparam logic [TIMER_W-1:0] T_HIGH  = TIMER_W'(HIGH_CYCLES);
  localparam logic [TIMER_W-1:0] T_LOW   = TIMER_W'(LOW_CYCLES);
  localparam logic [TIMER_W-1:0] T_SETUP = TIMER_W'(DIR_SETUP_CYCLES);

  state_e                     state_q, state_d;
  logic                       step_q, step_d;
  logic                       dir_q, dir_d;
  logic                       ovf_q, ovf_d;
  logic signed [PEND_W-1:0]   pend_q, pend_d;

  logic                       tmr_load;
  logic [TIMER_W-1:0]         tmr_val;
  logic                       tmr_done;
  logic                       emit;
  logic                       want;
  logic                       pend_nz;

  int                         inc;
  int                         dec;
  int                         sum;

  step_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign pend_nz = (pend_q != '0);
  assign want    = pend_nz && !pend_q[PEND_W-1];

  // A step may only start once dir_out already matches the sign of the backlog.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    dir_d    = dir_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    emit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && pend_nz) begin
          tmr_load = 1'b1;
          if (want != dir_q) begin
            dir_d   = want;
            state_d = ST_SETUP;
            tmr_val = T_SETUP;
          end else begin
            state_d = ST_HIGH;
            step_d  = 1'b1;
            tmr_val = T_HIGH;
            emit    = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          if (!pend_nz) begin
            state_d = ST_IDLE;
          end else if (want != dir_q) begin
            dir_d    = want;
            tmr_load = 1'b1;
            tmr_val  = T_SETUP;
          end else begin
            state_d  = ST_HIGH;
            step_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = T_HIGH;
            emit     = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (tmr_done) begin
          state_d  = ST_LOW;
          step_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = T_LOW;
        end
      end
      ST_LOW: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 1'b0;
      end
    endcase
  end

  // On saturation the new request is discarded but an emitted step still counts.
  always_comb begin
    inc   = 0;
    dec   = 0;
    ovf_d = ovf_q;
    if (step_req) inc = dir_req ? 1 : -1;
    if (emit)     dec = dir_q ? 1 : -1;
    sum    = int'(pend_q) + inc - dec;
    pend_d = PEND_W'(sum);
    if ((sum > PEND_MAX) || (sum < -PEND_MAX)) begin
      pend_d = PEND_W'(int'(pend_q) - dec);
      ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
    end
  end

  assign step_out = step_q;
  assign dir_out  = dir_q;
  assign overflow = ovf_q;
  assign pending  = pend_q;
  assign busy     = (state_q != ST_IDLE) || pend_nz;

endmodule

// File: tb/tb_step_pulse_shaper.sv
// Scoreboarded bench for step_pulse_shaper: scenarios queue the pulses they expect,
// a negedge monitor pops one entry per STEP rising edge and checks width/period.
module tb_step_pulse_shaper;

  localparam int HIGH  = 4;
  localparam int LOW   = 4;
  localparam int SETUP = 2;
  localparam int PW    = 4;

  typedef struct {
    logic dir;
    int   pend;
    logic ovf;
    int   period;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step_req = 1'b0;
  logic dir_req = 1'b0;
  logic enable = 1'b0;
  logic step_out;
  logic dir_out;
  logic busy;
  logic overflow;
  logic signed [PW-1:0] pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_count = 0;

  exp_t sb[$];
  exp_t mon_e;
  logic mon_prev = 1'b0;
  int   mon_high = 0;
  int   mon_last_rise = 0;

  step_pulse_shaper #(
    .HIGH_CYCLES      (HIGH),
    .LOW_CYCLES       (LOW),
    .DIR_SETUP_CYCLES (SETUP),
    .PEND_W           (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .step_req (step_req),
    .dir_req  (dir_req),
    .enable   (enable),
    .step_out (step_out),
    .dir_out  (dir_out),
    .busy     (busy),
    .overflow (overflow),
    .pending  (pending)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #(40 * 20000);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic dir, input logic en);
    @(posedge clk);
    #1;
    step_req = req;
    dir_req  = dir;
    enable   = en;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    step_req = 1'b0;
    enable   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pushExp(input logic dir, input int pend, input logic ovf, input int period);
    exp_t e;
    e.dir    = dir;
    e.pend   = pend;
    e.ovf    = ovf;
    e.period = period;
    sb.push_back(e);
  endtask

  task automatic waitIdle(input int max_cycles, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " busy drops"}, int'(busy), 0);
    checkOutput({name, " scoreboard drained"}, sb.size(), 0);
  endtask

  // Monitor: one scoreboard entry per rising edge of step_out.
  always @(negedge clk) begin
    if (rst) begin
      mon_prev = 1'b0;
      mon_high = 0;
    end else begin
      if (step_out && !mon_prev) begin
        rise_count++;
        if (sb.size() == 0) begin
          checkOutput("unexpected pulse", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("pulse dir_out", int'(dir_out), int'(mon_e.dir));
          checkOutput("pulse pending", int'(pending), mon_e.pend);
          checkOutput("pulse overflow", int'(overflow), int'(mon_e.ovf));
          if (mon_e.period != 0)
            checkOutput("pulse period", cyc - mon_last_rise, mon_e.period);
        end
        mon_last_rise = cyc;
        mon_high = 1;
      end else if (step_out) begin
        mon_high++;
      end else if (mon_prev) begin
        checkOutput("pulse high width", mon_high, HIGH);
      end
      mon_prev = step_out;
    end
  end

  initial begin
    int r0;
    int n;

    // Reset state
    applyReset();
    @(negedge clk);
    checkOutput("reset step_out", int'(step_out), 0);
    checkOutput("reset dir_out", int'(dir_out), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset overflow", int'(overflow), 0);
    checkOutput("reset pending", int'(pending), 0);

    // 1: single +1 request with direction change
    pushExp(1'b1, 0, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("s1 pending n+1", int'(pending), 1);
    checkOutput("s1 step_out n+1", int'(step_out), 0);
    @(negedge clk);
    checkOutput("s1 dir_out n+2", int'(dir_out), 1);
    checkOutput("s1 step_out n+2", int'(step_out), 0);
    @(negedge clk);
    checkOutput("s1 step_out n+3", int'(step_out), 0);
    repeat (4) @(negedge clk);
    checkOutput("s1 step_out n+7", int'(step_out), 1);
    @(negedge clk);
    checkOutput("s1 step_out n+8", int'(step_out), 0);
    repeat (3) @(negedge clk);
    checkOutput("s1 busy n+11", int'(busy), 1);
    @(negedge clk);
    checkOutput("s1 busy n+12", int'(busy), 0);
    waitIdle(50, "s1");

    // 2: five back-to-back -1 requests, no setup
    applyReset();
    pushExp(1'b0, -1, 1'b0, 0);
    pushExp(1'b0, -3, 1'b0, 9);
    pushExp(1'b0, -2, 1'b0, 9);
    pushExp(1'b0, -1, 1'b0, 9);
    pushExp(1'b0,  0, 1'b0, 9);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitIdle(120, "s2");
    checkOutput("s2 dir_out", int'(dir_out), 0);

    // 3: +3 and -1 while disabled nets to two pulses
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("s3 pending disabled", int'(pending), 2);
    checkOutput("s3 busy disabled", int'(busy), 1);
    checkOutput("s3 step_out disabled", int'(step_out), 0);
    pushExp(1'b1, 1, 1'b0, 0);
    pushExp(1'b1, 0, 1'b0, 9);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitIdle(100, "s3");
    checkOutput("s3 dir_out", int'(dir_out), 1);

    // 4: saturation at +7
    applyReset();
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("s4 pending saturated", int'(pending), 7);
    checkOutput("s4 overflow set", int'(overflow), 1);
    pushExp(1'b1, 6, 1'b1, 0);
    for (int k = 5; k >= 0; k--) pushExp(1'b1, k, 1'b1, 9);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitIdle(200, "s4");
    checkOutput("s4 overflow sticky", int'(overflow), 1);

    // 5: reset during HIGH truncates everything
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    pushExp(1'b1, 3, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!step_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("s5 reached HIGH", int'(step_out), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("s5 step_out after rst", int'(step_out), 0);
    checkOutput("s5 pending after rst", int'(pending), 0);
    checkOutput("s5 busy after rst", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    r0 = rise_count;
    repeat (30) @(negedge clk);
    checkOutput("s5 no pulses after rst", rise_count - r0, 0);
    checkOutput("s5 scoreboard drained", sb.size(), 0);

    // 6: request coinciding with HIGH entry leaves pending unchanged
    applyReset();
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    pushExp(1'b1, 2, 1'b0, 0);
    pushExp(1'b1, 1, 1'b0, 9);
    pushExp(1'b1, 0, 1'b0, 9);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("s6 pending at HIGH", int'(pending), 2);
    checkOutput("s6 step_out at HIGH", int'(step_out), 1);
    waitIdle(100, "s6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
